// File: rtl/eq_band_sequencer.sv
`timescale 1ns/1ps
// eq_band_sequencer: runs each sample through NUM_BANDS cascaded biquads and loads staged coefficients between samples.
// Optional feature macro EQ_BYPASS_EN adds a bypass input that returns accepted samples unprocessed.
module eq_band_sequencer #(
    parameter int unsigned NUM_BANDS = 4,
    parameter int unsigned BAND_W    = 3
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
`ifdef EQ_BYPASS_EN
    input  logic                    bypass,
`endif
    input  logic                    sample_valid,
    input  logic [15:0]             sample_in,
    output logic [15:0]             sample_out,
    output logic                    sample_out_valid,
    output logic                    overrun,
    input  logic                    cfg_we,
    input  logic [BAND_W-1:0]       cfg_band,
    input  logic [2:0]              cfg_sel,
    input  logic [17:0]             cfg_data,
    input  logic                    cfg_commit,
    output logic                    cfg_busy,
    output logic [15:0]             bq_sample_in,
    output logic [NUM_BANDS-1:0]    bq_new_sample,
    input  logic [NUM_BANDS-1:0]    bq_done,
    input  logic [16*NUM_BANDS-1:0] bq_sample_out,
    output logic [NUM_BANDS-1:0]    bq_new_coef,
    input  logic [NUM_BANDS-1:0]    bq_coef_updated,
    output logic [17:0]             bq_b0,
    output logic [17:0]             bq_b1,
    output logic [17:0]             bq_b2,
    output logic [17:0]             bq_a1,
    output logic [17:0]             bq_a2
);
    localparam int unsigned SMP_W  = 16;
    localparam int unsigned COEF_W = 18;
    localparam int unsigned NCOEF  = 5;
    localparam int unsigned SLOTS  = 1 << BAND_W;
    localparam logic [COEF_W-1:0] UNITY = 18'h04000;

    typedef enum logic [2:0] {IDLE, S_REQ, S_CAP, C_REQ, C_REL} state_t;

    state_t                 state_q, state_d;
    logic [BAND_W-1:0]      k_q, k_d, k_inc;
    logic                   last_band;
    logic                   pend_valid_q, pend_valid_d;
    logic [SMP_W-1:0]       pend_data_q, pend_data_d;
    logic                   overrun_d;
    logic                   commit_pending_q, commit_pending_d;
    logic [SMP_W-1:0]       sample_out_d, bq_sample_in_d;
    logic                   sample_out_valid_d;
    logic [NUM_BANDS-1:0]   bq_new_sample_d, bq_new_coef_d;
    logic [COEF_W-1:0]      coef_q [NCOEF];
    logic [COEF_W-1:0]      coef_d [NCOEF];
    logic [COEF_W-1:0]      stg [SLOTS][NCOEF];
    logic [SMP_W-1:0]       band_out [SLOTS];
    logic [SLOTS-1:0]       done_ext, upd_ext;
    logic                   take_sample, take_bypass_c, stg_we_c;

`ifdef EQ_BYPASS_EN
    assign take_bypass_c = bypass;
`else
    assign take_bypass_c = 1'b0;
`endif

    // Pad per-band inputs to the full index range of k so every lookup is exact-width.
    assign done_ext = SLOTS'(bq_done);
    assign upd_ext  = SLOTS'(bq_coef_updated);
    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        if (g < NUM_BANDS) begin : g_band
            assign band_out[g] = bq_sample_out[SMP_W*g +: SMP_W];
        end else begin : g_pad
            assign band_out[g] = '0;
        end
    end

    assign k_inc     = k_q + BAND_W'(1);
    assign last_band = (32'(k_q) == NUM_BANDS - 1);
    assign cfg_busy  = commit_pending_q;
    assign bq_b0 = coef_q[0];
    assign bq_b1 = coef_q[1];
    assign bq_b2 = coef_q[2];
    assign bq_a1 = coef_q[3];
    assign bq_a2 = coef_q[4];

    function automatic logic [NUM_BANDS-1:0] band_bit(input logic [BAND_W-1:0] idx);
        return NUM_BANDS'(SLOTS'(1) << idx);
    endfunction

    assign stg_we_c = cfg_we && !commit_pending_q && (32'(cfg_band) < NUM_BANDS) && (cfg_sel <= 3'd4);

    // Staging bank; frozen while a commit is being applied.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int b = 0; b < int'(SLOTS); b++) begin
                for (int j = 0; j < int'(NCOEF); j++) begin
                    stg[b][j] <= (j == 0) ? UNITY : '0;
                end
            end
        end else if (stg_we_c) begin
            stg[cfg_band][cfg_sel] <= cfg_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q          <= IDLE;
            k_q              <= '0;
            pend_valid_q     <= 1'b0;
            pend_data_q      <= '0;
            overrun          <= 1'b0;
            commit_pending_q <= 1'b0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            bq_sample_in     <= '0;
            bq_new_sample    <= '0;
            bq_new_coef      <= '0;
            for (int j = 0; j < int'(NCOEF); j++) coef_q[j] <= '0;
        end else begin
            state_q          <= state_d;
            k_q              <= k_d;
            pend_valid_q     <= pend_valid_d;
            pend_data_q      <= pend_data_d;
            overrun          <= overrun_d;
            commit_pending_q <= commit_pending_d;
            sample_out       <= sample_out_d;
            sample_out_valid <= sample_out_valid_d;
            bq_sample_in     <= bq_sample_in_d;
            bq_new_sample    <= bq_new_sample_d;
            bq_new_coef      <= bq_new_coef_d;
            for (int j = 0; j < int'(NCOEF); j++) coef_q[j] <= coef_d[j];
        end
    end

    always_comb begin
        state_d            = state_q;
        k_d                = k_q;
        take_sample        = 1'b0;
        pend_valid_d       = pend_valid_q;
        pend_data_d        = pend_data_q;
        overrun_d          = overrun;
        commit_pending_d   = commit_pending_q;
        sample_out_d       = sample_out;
        sample_out_valid_d = 1'b0;
        bq_sample_in_d     = bq_sample_in;
        bq_new_sample_d    = '0;
        bq_new_coef_d      = '0;
        for (int j = 0; j < int'(NCOEF); j++) coef_d[j] = coef_q[j];

        unique case (state_q)
            IDLE: begin
                // Samples win over a waiting commit.
                if (pend_valid_q) begin
                    take_sample = 1'b1;
                    if (take_bypass_c) begin
                        sample_out_d       = pend_data_q;
                        sample_out_valid_d = 1'b1;
                    end else begin
                        state_d         = S_REQ;
                        k_d             = '0;
                        bq_sample_in_d  = pend_data_q;
                        bq_new_sample_d = band_bit('0);
                    end
                end else if (commit_pending_q) begin
                    state_d       = C_REQ;
                    k_d           = '0;
                    bq_new_coef_d = band_bit('0);
                    for (int j = 0; j < int'(NCOEF); j++) coef_d[j] = stg[0][j];
                end
            end
            S_REQ: begin
                if (done_ext[k_q]) state_d = S_CAP;
                else               bq_new_sample_d = band_bit(k_q);
            end
            S_CAP: begin
                // Band output register settles one edge after done; it feeds the next band.
                bq_sample_in_d = band_out[k_q];
                if (last_band) begin
                    sample_out_d       = band_out[k_q];
                    sample_out_valid_d = 1'b1;
                    state_d            = IDLE;
                end else begin
                    k_d             = k_inc;
                    state_d         = S_REQ;
                    bq_new_sample_d = band_bit(k_inc);
                end
            end
            C_REQ: begin
                if (upd_ext[k_q]) state_d = C_REL;
                else              bq_new_coef_d = band_bit(k_q);
            end
            C_REL: begin
                if (last_band) begin
                    commit_pending_d = 1'b0;
                    state_d          = IDLE;
                end else begin
                    k_d           = k_inc;
                    state_d       = C_REQ;
                    bq_new_coef_d = band_bit(k_inc);
                    for (int j = 0; j < int'(NCOEF); j++) coef_d[j] = stg[k_inc][j];
                end
            end
            default: state_d = IDLE;
        endcase

        // One-entry pending slot; a refill in the consuming cycle is not an overrun.
        if (sample_valid) begin
            pend_valid_d = 1'b1;
            pend_data_d  = sample_in;
            if (pend_valid_q && !take_sample) overrun_d = 1'b1;
        end else if (take_sample) begin
            pend_valid_d = 1'b0;
        end

        if (cfg_commit && !commit_pending_q) commit_pending_d = 1'b1;
    end
endmodule

// File: tb/tb_eq_band_sequencer.sv
`timescale 1ns/1ps
// tb_eq_band_sequencer: directed bench driving the sequencer against b0-gain biquad models with an output scoreboard.
module tb_eq_band_sequencer;
    localparam int NB  = 4;
    localparam int BW  = 3;
    localparam int LAT = 4 * NB;
    localparam logic [17:0] UNITY = 18'h04000;

    logic           Clk, Reset_n;
    logic           sample_valid;
    logic [15:0]    sample_in, sample_out;
    logic           sample_out_valid, overrun;
    logic           cfg_we, cfg_commit, cfg_busy;
    logic [BW-1:0]  cfg_band;
    logic [2:0]     cfg_sel;
    logic [17:0]    cfg_data;
    logic [15:0]    bq_sample_in;
    logic [NB-1:0]  bq_new_sample, bq_done, bq_new_coef, bq_coef_updated;
    logic [16*NB-1:0] bq_sample_out;
    logic [17:0]    bq_b0, bq_b1, bq_b2, bq_a1, bq_a2;
`ifdef EQ_BYPASS_EN
    logic           bypass;
    initial bypass = 1'b0;
`endif

    eq_band_sequencer #(.NUM_BANDS(NB), .BAND_W(BW)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
`ifdef EQ_BYPASS_EN
        .bypass(bypass),
`endif
        .sample_valid(sample_valid), .sample_in(sample_in),
        .sample_out(sample_out), .sample_out_valid(sample_out_valid), .overrun(overrun),
        .cfg_we(cfg_we), .cfg_band(cfg_band), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
        .bq_sample_in(bq_sample_in), .bq_new_sample(bq_new_sample), .bq_done(bq_done),
        .bq_sample_out(bq_sample_out), .bq_new_coef(bq_new_coef), .bq_coef_updated(bq_coef_updated),
        .bq_b0(bq_b0), .bq_b1(bq_b1), .bq_b2(bq_b2), .bq_a1(bq_a1), .bq_a2(bq_a2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Biquad models: pure b0 gain, done after m_delay+1 edges, output one edge after done.
    logic        m_done [NB];
    logic        m_upd  [NB];
    logic [15:0] m_out  [NB];
    int          m_scnt [NB];
    int          m_ccnt [NB];
    int          m_delay[NB];
    logic [17:0] m_cf   [NB][5];

    function automatic logic [15:0] gain(input logic [15:0] x, input logic [17:0] c);
        logic signed [33:0] p;
        p = 34'($signed(x)) * 34'($signed(c));
        return p[29:14];
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NB; i++) begin
                m_done[i] <= 1'b0; m_upd[i] <= 1'b0; m_out[i] <= '0;
                m_scnt[i] <= 0;    m_ccnt[i] <= 0;
                for (int j = 0; j < 5; j++) m_cf[i][j] <= (j == 0) ? UNITY : 18'h0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (bq_new_sample[i] && !m_done[i]) begin
                    if (m_scnt[i] >= m_delay[i]) begin m_done[i] <= 1'b1; m_scnt[i] <= 0; end
                    else m_scnt[i] <= m_scnt[i] + 1;
                end else if (m_done[i] && bq_new_sample[i]) begin
                    m_out[i] <= gain(bq_sample_in, m_cf[i][0]);
                end else if (m_done[i]) begin
                    m_done[i] <= 1'b0;
                end
                if (bq_new_coef[i] && !m_upd[i]) begin
                    if (m_ccnt[i] >= 1) begin
                        m_upd[i] <= 1'b1; m_ccnt[i] <= 0;
                        m_cf[i][0] <= bq_b0; m_cf[i][1] <= bq_b1; m_cf[i][2] <= bq_b2;
                        m_cf[i][3] <= bq_a1; m_cf[i][4] <= bq_a2;
                    end else m_ccnt[i] <= m_ccnt[i] + 1;
                end else if (m_upd[i] && !bq_new_coef[i]) begin
                    m_upd[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_pack
        assign bq_done[g]                 = m_done[g];
        assign bq_coef_updated[g]         = m_upd[g];
        assign bq_sample_out[16*g +: 16]  = m_out[g];
    end

    int checks = 0, errors = 0;
    int cyc, overlap, first_coef, busy_fall, t0, ot0;
    logic [NB-1:0] prev_coef;
    logic          prev_busy;
    logic [15:0]   exp_q[$], obs_q[$];
    int            exp_t[$], obs_t[$], coef_order[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NB-1:0] v);
        for (int i = 0; i < NB; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Advance one cycle and record everything observable just after the edge.
    task automatic step();
        @(posedge Clk); #1;
        cyc++;
        if (sample_out_valid) begin obs_q.push_back(sample_out); obs_t.push_back(cyc); end
        if ($countones({bq_new_sample, bq_new_coef}) > 1) overlap++;
        if (bq_new_coef != '0 && prev_coef == '0) begin
            coef_order.push_back(oh_idx(bq_new_coef));
            if (first_coef == 0) first_coef = cyc;
        end
        if (prev_busy && !cfg_busy) busy_fall = cyc;
        prev_coef = bq_new_coef;
        prev_busy = cfg_busy;
    endtask

    task automatic send(input logic [15:0] x);
        sample_valid = 1'b1; sample_in = x;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] v, input int t);
        exp_q.push_back(v); exp_t.push_back(t);
    endtask

    task automatic cfg_write(input logic [BW-1:0] b, input logic [2:0] s, input logic [17:0] d);
        cfg_we = 1'b1; cfg_band = b; cfg_sel = s; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic commit();
        coef_order.delete(); first_coef = 0; busy_fall = 0;
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
    endtask

    task automatic wait_commit(input int budget);
        int b = 0;
        while (cfg_busy && b < budget) begin step(); b++; end
        check("commit_done", 32'(cfg_busy), 32'(0));
    endtask

    task automatic check_order();
        check("coef_order_len", 32'(coef_order.size()), 32'(NB));
        for (int i = 0; i < NB && i < coef_order.size(); i++)
            check("coef_order", 32'(coef_order[i]), 32'(i));
    endtask

    task automatic expect_outputs(input int budget);
        int n = exp_q.size();
        int b = 0;
        logic [15:0] ev, ov;
        int et, ot;
        while (obs_q.size() < n && b < budget) begin step(); b++; end
        check("out_count", 32'(obs_q.size()), 32'(n));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev = exp_q.pop_front(); et = exp_t.pop_front();
            ov = obs_q.pop_front(); ot = obs_t.pop_front();
            check("out_value", 32'(ov), 32'(ev));
            if (et != 0) check("out_latency", 32'(ot), 32'(et));
        end
        exp_q.delete(); exp_t.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sample_out"}, 32'(sample_out), 32'(0));
        check({tag, "_valid"},      32'(sample_out_valid), 32'(0));
        check({tag, "_overrun"},    32'(overrun), 32'(0));
        check({tag, "_busy"},       32'(cfg_busy), 32'(0));
        check({tag, "_new_sample"}, 32'(bq_new_sample), 32'(0));
        check({tag, "_new_coef"},   32'(bq_new_coef), 32'(0));
        check({tag, "_bus"},        32'({bq_sample_in, 16'h0} | 32'(bq_b0 | bq_b1 | bq_b2 | bq_a1 | bq_a2)), 32'(0));
    endtask

    initial begin
        int b;
        Reset_n = 1'b0; sample_valid = 1'b0; sample_in = '0;
        cfg_we = 1'b0; cfg_band = '0; cfg_sel = '0; cfg_data = '0; cfg_commit = 1'b0;
        cyc = 0; overlap = 0; first_coef = 0; busy_fall = 0; prev_coef = '0; prev_busy = 1'b0;
        for (int i = 0; i < NB; i++) m_delay[i] = 1;
        repeat (3) step();
        check_zero("reset");
        Reset_n = 1'b1;
        step();

        // Identity path from reset defaults.
        send(16'h1234); push_exp(16'h1234, cyc + 1 + LAT);
        expect_outputs(40);

        // Staging writes, ignored writes, then commit.
        cfg_write(3'd2, 3'd0, 18'h02000);
        cfg_write(3'd1, 3'd3, 18'h3F000);
        cfg_write(3'd1, 3'd5, 18'h3FFFF);
        cfg_write(3'd4, 3'd0, 18'h00001);
        commit();
        check("busy_after_commit", 32'(cfg_busy), 32'(1));
        cfg_write(3'd3, 3'd0, 18'h01000);
        wait_commit(60);
        check_order();
        check("commit_duration", 32'(busy_fall - first_coef), 32'(LAT));
        check("band2_b0", 32'(m_cf[2][0]), 32'(18'h02000));
        check("band1_a1", 32'(m_cf[1][3]), 32'(18'h3F000));
        check("band1_b1_a2", 32'({m_cf[1][1], m_cf[1][4]}), 32'(0));
        check("band0_b0", 32'(m_cf[0][0]), 32'(UNITY));
        send(16'h1000); push_exp(16'h0800, cyc + 1 + LAT);
        expect_outputs(40);

        // Commit strobe while band 1 is processing a sample.
        send(16'h2000); push_exp(16'h1000, cyc + 1 + LAT);
        b = 0;
        while (bq_new_sample !== 4'b0010 && b < 40) begin step(); b++; end
        check("reach_band1", 32'(bq_new_sample), 32'(4'b0010));
        overlap = 0;
        commit();
        wait_commit(80);
        ot0 = (obs_t.size() > 0) ? obs_t[0] : -1;
        check("commit_after_sample", 32'(first_coef), 32'(ot0 + 1));
        check_order();
        check("no_overlap", 32'(overlap), 32'(0));
        expect_outputs(10);
        check("busy_write_ignored", 32'(m_cf[3][0]), 32'(UNITY));

        // Refill in the consuming cycle is not an overrun.
        sample_valid = 1'b1; sample_in = 16'h0100; step(); t0 = cyc;
        sample_in = 16'h0300; step(); sample_valid = 1'b0;
        push_exp(16'h0080, t0 + 1 + LAT); push_exp(16'h0180, t0 + 2 + 2 * LAT);
        expect_outputs(80);
        check("no_overrun", 32'(overrun), 32'(0));

        // Three samples two cycles apart: third overwrites second.
        send(16'h0400); t0 = cyc; step();
        send(16'h0600); step();
        send(16'h0800);
        push_exp(16'h0200, t0 + 1 + LAT); push_exp(16'h0400, t0 + 2 + 2 * LAT);
        expect_outputs(80);
        repeat (30) step();
        check("extra_outputs", 32'(obs_q.size()), 32'(0));
        check("overrun_set", 32'(overrun), 32'(1));

        // Band 1 answers 10 cycles late.
        m_delay[1] = 11;
        send(16'h1234); push_exp(16'h091A, cyc + 1 + LAT + 10);
        expect_outputs(80);
        m_delay[1] = 1;

        // Reset while band 2 is taking coefficients.
        cfg_write(3'd0, 3'd0, 18'h01000);
        commit();
        b = 0;
        while (bq_new_coef !== 4'b0100 && b < 40) begin step(); b++; end
        check("reach_c_req2", 32'(bq_new_coef), 32'(4'b0100));
        Reset_n = 1'b0; #1;
        check_zero("midreset");
        step(); step();
        Reset_n = 1'b1;
        step();
        obs_q.delete(); obs_t.delete();
        commit();
        wait_commit(60);
        check_order();
        check("restored_b0_band0", 32'(m_cf[0][0]), 32'(UNITY));
        check("restored_b0_band2", 32'(m_cf[2][0]), 32'(UNITY));
        check("restored_a1_band1", 32'(m_cf[1][3]), 32'(0));
        send(16'h1234); push_exp(16'h1234, cyc + 1 + LAT);
        expect_outputs(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/eq_band_sequencer.md
Name: eq_band_sequencer

Overview:
- Sequences a cascade of NUM_BANDS biquad sections forming the parametric equalizer. One input sample runs through band 0, then band 1, and so on in order.
- Holds a host-writable staging bank of coefficients for each band. On commit, it loads them into the sections only in gaps between samples.
- Owns every new_sample/new_coefficients handshake, so band instances never see overlapping requests.

Parameters:
- NUM_BANDS, 4, number of cascaded biquad sections (1..8).
- BAND_W, 3, width of cfg_band. Must satisfy 2**BAND_W >= NUM_BANDS.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset. The top level drives each biquad Reset with ~Reset_n.
- sample_valid  in  1  one-cycle strobe; sample_in is valid.
- sample_in  in  16  signed input sample.
- sample_out  out  16  signed equalized sample.
- sample_out_valid  out  1  one-cycle strobe; sample_out updated.
- overrun  out  1  sticky; a pending sample was overwritten. Cleared only by reset.
- cfg_we  in  1  write one staging coefficient.
- cfg_band  in  BAND_W  band index for the write.
- cfg_sel  in  3  coefficient select: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2. Values 5..7 are ignored.
- cfg_data  in  18  signed 4.14 coefficient.
- cfg_commit  in  1  strobe; load all staging values into the bands.
- cfg_busy  out  1  commit accepted but not finished.
- bq_sample_in  out  16  shared sample bus to all bands.
- bq_new_sample  out  NUM_BANDS  per-band new_sample.
- bq_done  in  NUM_BANDS  per-band computation_done.
- bq_sample_out  in  16*NUM_BANDS  per-band sample_out; band k occupies bits [16k+15:16k].
- bq_new_coef  out  NUM_BANDS  per-band new_coefficients.
- bq_coef_updated  in  NUM_BANDS  per-band coefficients_updated.
- bq_b0, bq_b1, bq_b2, bq_a1, bq_a2  out  18 each  shared coefficient buses.

Behaviour:
- Reset (async):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Staging bank: b0 = 18'h04000 (1.0) for every band; all other coefficients 0.
  - pending, commit_pending and overrun are cleared.
  - Any handshake in progress is abandoned. Biquads are reset at the same time.
- All outputs are registered.
- Staging writes:
  - cfg_we with cfg_band < NUM_BANDS and cfg_sel <= 4 writes staging[cfg_band][cfg_sel]. Any other combination is ignored.
  - Writes are ignored while cfg_busy = 1.
- Commit:
  - cfg_commit with cfg_busy = 0 sets commit_pending and asserts cfg_busy on the next cycle.
  - cfg_commit while busy is ignored.
- Sample input:
  - sample_valid loads a one-entry pending register.
  - If pending is already full, the new sample overwrites it and overrun is set.
  - sample_valid in the same cycle that pending is consumed refills pending; this is not an overrun.
- FSM states:
  - IDLE: if pending, go to S_REQ with band k = 0 (samples have priority). Otherwise, if commit_pending, go to C_REQ with k = 0.
  - S_REQ: drive bq_sample_in (pending value for k = 0, captured value otherwise) and hold bq_new_sample[k] = 1 until bq_done[k] = 1. Then drop new_sample and go to S_CAP.
  - S_CAP: capture bq_sample_out[k]. This cycle is required: the biquad output register updates one edge after done is seen. Then:
    - if k < NUM_BANDS-1, increment k and go to S_REQ;
    - otherwise drive sample_out, pulse sample_out_valid and go to IDLE.
  - C_REQ: drive bq_b0..bq_a2 from staging[k] and hold bq_new_coef[k] = 1 until bq_coef_updated[k] = 1. Then drop new_coef and go to C_REL.
  - C_REL: keep the buses stable for one cycle so the band returns to its reset state. Then:
    - if k < NUM_BANDS-1, increment k and go to C_REQ;
    - otherwise clear commit_pending and cfg_busy and go to IDLE.
- A commit in progress is not preempted. Samples that arrive during a commit wait in pending.
- At most one bq_new_sample or bq_new_coef bit is high in any cycle. The two never overlap.
- Latency with conforming biquads: each band takes 4 cycles. sample_out_valid rises 4*NUM_BANDS cycles after the edge that accepts the sample from IDLE (16 cycles for 4 bands). A full commit takes 4*NUM_BANDS cycles.
- Each handshake wait is unbounded; the FSM advances only on bq_done or bq_coef_updated, never on a cycle count.

Optional Feature:
- Macro: EQ_BYPASS_EN.
- When defined:
  - Adds input port bypass (1 bit).
  - If bypass = 1 when IDLE accepts a pending sample, sample_out = the pending sample and sample_out_valid pulses on the next cycle. No bq_new_sample is raised and band state is untouched.
  - Commits still run normally.
- When undefined: no bypass port; every sample passes through all bands.

Test Plan:
- Reset defaults with identity biquad models: sample_in = 16'h1234 -> sample_out = 16'h1234, sample_out_valid 16 cycles after acceptance.
- Staging writes and commit:
  - Write band 2 b0 = 18'h02000 (0.5), then commit.
  - cfg_busy is high for 16 cycles.
  - bq_new_coef pulses in order 0,1,2,3; band 2 latches 18'h02000.
  - Input 16'h1000 -> output 16'h0800.
- Commit during a sample: commit strobe while the FSM is in S_REQ band 1 -> sample completes first, then 4 coefficient loads follow. Check that new_sample and new_coef never overlap.
- Overrun: three sample_valid pulses 2 cycles apart -> first is processed, third overwrites second, overrun = 1, exactly two sample_out_valid pulses.
- Slow handshake: band 1 model delays done by 10 cycles -> the FSM waits, latency becomes 26 cycles, output is correct.
- Reset mid-commit: deassert Reset_n during C_REQ band 2 -> all outputs 0, cfg_busy = 0, staging restored to b0 = 18'h04000.
